// File: rtl/shifter_arbiter.sv
// Round-robin share of one combinational barrel shifter between two requesters; Gnt one cycle after Req, Done the cycle after.
// One operation in flight; a requester holds Req until Gnt, the block holds Done/Res until that requester's Ack.
module shifter_arbiter #(
  parameter int WIDTH      = 16,
  parameter int SHW        = 4,
  parameter int FIRST_PRIO = 0
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Req0,
  input  logic [WIDTH-1:0] Data0,
  input  logic [SHW-1:0]   Shamt0,
  input  logic [1:0]       Funct0,
  output logic             Gnt0,
  output logic             Done0,
  output logic [WIDTH-1:0] Res0,
  input  logic             Ack0,
  input  logic             Req1,
  input  logic [WIDTH-1:0] Data1,
  input  logic [SHW-1:0]   Shamt1,
  input  logic [1:0]       Funct1,
  output logic             Gnt1,
  output logic             Done1,
  output logic [WIDTH-1:0] Res1,
  input  logic             Ack1,
  output logic [WIDTH-1:0] Sh_Hyrja,
  output logic [SHW-1:0]   Sh_Shamt,
  output logic [1:0]       Sh_Funct,
  input  logic [WIDTH-1:0] Sh_Result,
  output logic             Busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Pointer holds the last-served id, so the opposite id wins the first tie.
  localparam logic PTR_RST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

  state_t           r_state;
  state_t           w_next;
  logic             r_sel;
  logic             r_ptr;
  logic [WIDTH-1:0] r_opnd;
  logic [SHW-1:0]   r_shamt;
  logic [1:0]       r_funct;
  logic [WIDTH-1:0] r_res0;
  logic [WIDTH-1:0] r_res1;
  logic             w_any;
  logic             w_pick;
  logic             w_ack;

  assign w_any  = Req0 | Req1;
  assign w_pick = Req1 & (~Req0 | ~r_ptr);
  assign w_ack  = r_sel ? Ack1 : Ack0;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (w_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_sel   <= 1'b0;
      r_ptr   <= PTR_RST;
      r_opnd  <= '0;
      r_shamt <= '0;
      r_funct <= '0;
      r_res0  <= '0;
      r_res1  <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_sel   <= w_pick;
        r_opnd  <= w_pick ? Data1  : Data0;
        r_shamt <= w_pick ? Shamt1 : Shamt0;
        r_funct <= w_pick ? Funct1 : Funct0;
      end
      if (r_state == S_EXEC) begin
        if (r_sel) r_res1 <= Sh_Result;
        else       r_res0 <= Sh_Result;
      end
      if (r_state == S_RESP && w_ack) begin
        r_ptr <= r_sel;
      end
    end
  end

  // Shifter inputs stay on the latched operands between operations.
  assign Sh_Hyrja = r_opnd;
  assign Sh_Shamt = r_shamt;
  assign Sh_Funct = r_funct;

  assign Gnt0  = (r_state == S_EXEC) && !r_sel;
  assign Gnt1  = (r_state == S_EXEC) &&  r_sel;
  assign Done0 = (r_state == S_RESP) && !r_sel;
  assign Done1 = (r_state == S_RESP) &&  r_sel;
  assign Res0  = r_res0;
  assign Res1  = r_res1;
  assign Busy  = (r_state != S_IDLE);

endmodule
